// File: rtl/div_ctrl_unit.sv
// Control wrapper for an iterative SRT4 divider: captures RV64 DIV/DIVU/REM/REMU(W) ops,
// short-circuits divide-by-zero and signed overflow, and holds the result until consumed.
module div_ctrl_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic             word_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    input  logic             flush_i,
    output logic             div_start_o,
    output logic             div_sign_o,
    output logic [WIDTH-1:0] div_divd_o,
    output logic [WIDTH-1:0] div_div_o,
    input  logic [WIDTH-1:0] div_q_i,
    input  logic [WIDTH-1:0] div_rem_i,
    input  logic             div_finish_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       r_state;
    logic             r_sign;
    logic             r_word;
    logic             r_rem;
    logic [WIDTH-1:0] r_divd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;

    logic             w_signed;
    logic             w_accept;
    logic [WIDTH-1:0] w_divd_ext;
    logic [WIDTH-1:0] w_div_ext;
    logic [WIDTH-1:0] w_min;
    logic             w_div_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_spec_res;

    // DIV and REM are the signed ops (op_i[0] == 0)
    assign w_signed   = ~op_i[0];
    assign w_divd_ext = word_i ? {{(WIDTH-32){w_signed & rs1_i[31]}}, rs1_i[31:0]} : rs1_i;
    assign w_div_ext  = word_i ? {{(WIDTH-32){w_signed & rs2_i[31]}}, rs2_i[31:0]} : rs2_i;
    assign w_min      = word_i ? {{(WIDTH-31){1'b1}}, {31{1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};

    assign w_div_zero = (w_div_ext == '0);
    assign w_ovf      = w_signed && (w_divd_ext == w_min) && (w_div_ext == '1);

    always_comb begin
        w_spec_res = '0;
        if (w_div_zero) begin
            w_spec_res = op_i[1] ? w_divd_ext : '1;
        end else begin
            w_spec_res = op_i[1] ? '0 : w_divd_ext;
        end
    end

    assign ready_o  = (r_state == IDLE);
    assign w_accept = valid_i && ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_word   <= 1'b0;
            r_rem    <= 1'b0;
            r_divd   <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else if (flush_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_signed;
                        r_word <= word_i;
                        r_rem  <= op_i[1];
                        r_divd <= w_divd_ext;
                        r_div  <= w_div_ext;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_spec_res;
                            r_state  <= DONE;
                        end else begin
                            r_state <= START;
                        end
                    end
                end
                START: r_state <= WAIT;
                // The divider may already be done in the first WAIT cycle
                WAIT: begin
                    if (div_finish_i) begin
                        r_result <= r_rem ? div_rem_i : div_q_i;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid_o     = (r_state == DONE);
    assign div_start_o = (r_state == START);
    assign div_sign_o  = r_sign;
    assign div_divd_o  = r_divd;
    assign div_div_o   = r_div;
    assign result_o    = r_word ? {{(WIDTH-32){r_result[31]}}, r_result[31:0]} : r_result;

endmodule

// File: tb/tb_div_ctrl_unit.sv
// Directed bench for div_ctrl_unit with a behavioural divider stub whose finish delay is
// set per scenario.
module tb_div_ctrl_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_i = 2'b00;
    logic        word_i = 1'b0;
    logic [63:0] rs1_i = '0;
    logic [63:0] rs2_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [63:0] result_o;
    logic        flush_i = 1'b0;
    logic        div_start_o;
    logic        div_sign_o;
    logic [63:0] div_divd_o;
    logic [63:0] div_div_o;
    logic [63:0] div_q_i;
    logic [63:0] div_rem_i;
    logic        div_finish_i;

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;
    int fin_delay = 0;
    bit fin_en = 1'b1;
    bit fin_force = 1'b0;
    int start_cnt = 0;

    div_ctrl_unit #(.WIDTH(64)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .word_i       (word_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .flush_i      (flush_i),
        .div_start_o  (div_start_o),
        .div_sign_o   (div_sign_o),
        .div_divd_o   (div_divd_o),
        .div_div_o    (div_div_o),
        .div_q_i      (div_q_i),
        .div_rem_i    (div_rem_i),
        .div_finish_i (div_finish_i)
    );

    always #5 clk_i = ~clk_i;

    // Divider stub: combinational on the registered operands, finish after fin_delay cycles
    always_comb begin
        div_q_i   = '0;
        div_rem_i = '0;
        if (div_div_o != '0) begin
            if (div_sign_o && div_div_o == '1) begin
                div_q_i = '0 - div_divd_o;
            end else if (div_sign_o) begin
                div_q_i   = $signed(div_divd_o) / $signed(div_div_o);
                div_rem_i = $signed(div_divd_o) % $signed(div_div_o);
            end else begin
                div_q_i   = div_divd_o / div_div_o;
                div_rem_i = div_divd_o % div_div_o;
            end
        end
    end

    assign div_finish_i = fin_force || (fin_en && !div_start_o && fin_cnt >= fin_delay);

    always @(posedge clk_i) begin
        fin_cnt <= div_start_o ? 0 : fin_cnt + 1;
        if (div_start_o) start_cnt <= start_cnt + 1;
    end

    task automatic do_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
        op_i = op; word_i = word; rs1_i = a; rs2_i = b; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_o); end
        checks++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", div_start_o); end
        checks++; if (div_sign_o !== 1'b0) begin errors++; $display("FAIL rst_sign got %b exp 0", div_sign_o); end
        checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL rst_result got %h exp 0", result_o); end
        checks++; if (div_divd_o !== 64'h0 || div_div_o !== 64'h0) begin
            errors++; $display("FAIL rst_operands got %h/%h exp 0/0", div_divd_o, div_div_o);
        end
        @(negedge clk_i); rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_divu();
        logic [63:0] res; int lat; int s0;
        fin_en = 1'b1; fin_delay = 2; s0 = start_cnt;
        do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, res, lat);
        checks++; if (res !== 64'd14) begin errors++; $display("FAIL divu_res got %0d exp 14", res); end
        checks++; if (lat != 5) begin errors++; $display("FAIL divu_lat got %0d exp 5", lat); end
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL divu_start got %0d exp 1", start_cnt - s0); end
        checks++; if (div_sign_o !== 1'b0 || div_divd_o !== 64'd100) begin
            errors++; $display("FAIL divu_ctrl got sign %b divd %0d exp 0 100", div_sign_o, div_divd_o);
        end
        repeat (3) @(posedge clk_i); #1;
        checks++; if (valid_o !== 1'b1 || result_o !== 64'd14) begin
            errors++; $display("FAIL divu_hold got v %b r %0d exp 1 14", valid_o, result_o);
        end
        release_result();
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL divu_release got v %b rdy %b exp 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_signed();
        logic [63:0] res; int lat;
        fin_en = 1'b1; fin_delay = 1;
        do_op(OP_REM, 1'b0, -64'sd7, 64'd2, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_neg got %h exp ffffffffffffffff", res); end
        checks++; if (div_sign_o !== 1'b1) begin errors++; $display("FAIL rem_sign got %b exp 1", div_sign_o); end
        release_result();
        do_op(OP_DIV, 1'b0, -64'sd7, 64'd2, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg got %h exp fffffffffffffffd", res); end
        release_result();
        do_op(OP_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divw_res got %h exp fffffffffffffffd", res); end
        checks++; if (div_divd_o !== 64'hFFFF_FFFF_FFFF_FFF9) begin errors++; $display("FAIL divw_sext got %h exp fffffffffffffff9", div_divd_o); end
        release_result();
        do_op(OP_DIVU, 1'b1, 64'hDEAD_0000_0000_0064, 64'hBEEF_0000_0000_0007, res, lat);
        checks++; if (res !== 64'd14) begin errors++; $display("FAIL divuw_res got %h exp 14", res); end
        checks++; if (div_divd_o !== 64'h64) begin errors++; $display("FAIL divuw_zext got %h exp 64", div_divd_o); end
        release_result();
    endtask

    task automatic test_special();
        logic [63:0] res; int lat; int s0;
        s0 = start_cnt;
        do_op(OP_DIV, 1'b0, 64'd5, 64'd0, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dz_div got %h exp all-ones", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL dz_lat got %0d exp 1", lat); end
        release_result();
        do_op(OP_REMU, 1'b0, 64'd5, 64'd0, res, lat);
        checks++; if (res !== 64'd5) begin errors++; $display("FAIL dz_remu got %h exp 5", res); end
        release_result();
        do_op(OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL ovf_divw got %h exp ffffffff80000000", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL ovf_lat got %0d exp 1", lat); end
        release_result();
        do_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
        checks++; if (res !== 64'h0) begin errors++; $display("FAIL ovf_rem got %h exp 0", res); end
        release_result();
        checks++; if (start_cnt != s0) begin errors++; $display("FAIL special_start got %0d exp 0", start_cnt - s0); end
    endtask

    task automatic test_fast_finish();
        logic [63:0] res; int lat;
        fin_force = 1'b1;
        do_op(OP_DIVU, 1'b0, 64'd3, 64'd9, res, lat);
        fin_force = 1'b0;
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL fast_res got %h exp 0", res); end
        checks++; if (lat != 3) begin errors++; $display("FAIL fast_lat got %0d exp 3", lat); end
        release_result();
    endtask

    task automatic test_flush();
        logic [63:0] res; int lat; int s0;
        fin_en = 1'b0;
        op_i = OP_DIVU; word_i = 1'b0; rs1_i = 64'd1000; rs2_i = 64'd3; valid_i = 1'b1;
        @(posedge clk_i); #1;
        rs1_i = 64'd10;
        @(posedge clk_i); #1;
        s0 = start_cnt;
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b0 || start_cnt != s0) begin
            errors++; $display("FAIL busy_ignore got rdy %b starts %0d exp 0 0", ready_o, start_cnt - s0);
        end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || div_start_o !== 1'b0) begin
            errors++; $display("FAIL flush_wait got v %b rdy %b st %b exp 0 1 0", valid_o, ready_o, div_start_o);
        end
        fin_en = 1'b1; fin_delay = 1;
        do_op(OP_DIVU, 1'b0, 64'd10, 64'd3, res, lat);
        checks++; if (res !== 64'd3) begin errors++; $display("FAIL flush_new got %0d exp 3", res); end
        checks++; if (lat != 4) begin errors++; $display("FAIL flush_lat got %0d exp 4", lat); end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_done got %b exp 0", valid_o); end
        valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        checks++; if (div_start_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_prio got st %b rdy %b exp 0 1", div_start_o, ready_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int lat;
        fin_en = 1'b0;
        op_i = OP_DIVU; word_i = 1'b0; rs1_i = 64'd1000; rs2_i = 64'd3; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1 || result_o !== 64'h0 || div_divd_o !== 64'h0) begin
            errors++; $display("FAIL rst_mid got rdy %b r %h d %h exp 1 0 0", ready_o, result_o, div_divd_o);
        end
        @(negedge clk_i); rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        fin_en = 1'b1; fin_delay = 0;
        do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, res, lat);
        checks++; if (res !== 64'd14 || lat != 3) begin
            errors++; $display("FAIL rst_after got %0d lat %0d exp 14 3", res, lat);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_special();
        test_fast_finish();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl_unit.md
DIV_CTRL_UNIT -- requirements
Module: div_ctrl_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the operand and result width.
REQ-002 The port clk_i SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-003 The port rst_n_i SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 The port valid_i SHALL be an input, 1 bit wide: the issue stage presents a divide op.
REQ-005 The port ready_o SHALL be an output, 1 bit wide: the unit accepts an op; high only in IDLE.
REQ-006 The port op_i SHALL be an input, 2 bits wide: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 The port word_i SHALL be an input, 1 bit wide: when 1, selects the RV64 W variant (32-bit op).
REQ-008 The ports rs1_i and rs2_i SHALL be inputs, WIDTH bits each: dividend and divisor.
REQ-009 The port valid_o SHALL be an output, 1 bit wide: result_o is valid.
REQ-010 The port ready_i SHALL be an input, 1 bit wide: the consumer takes the result.
REQ-011 The port result_o SHALL be an output, WIDTH bits wide: quotient or remainder.
REQ-012 The port flush_i SHALL be an input, 1 bit wide: kills any in-flight op.
REQ-013 The port div_start_o SHALL be an output, 1 bit wide: single-cycle start pulse to the SRT4 divider.
REQ-014 The port div_sign_o SHALL be an output, 1 bit wide: the divider's signed-mode control.
REQ-015 The ports div_divd_o and div_div_o SHALL be outputs, WIDTH bits each: registered dividend and divisor to the divider.
REQ-016 The ports div_q_i and div_rem_i SHALL be inputs, WIDTH bits each: divider quotient and remainder.
REQ-017 The port div_finish_i SHALL be an input, 1 bit wide: divider completion flag, a level.

Function
REQ-018 The FSM SHALL have exactly four states:
- IDLE
- START
- WAIT
- DONE
REQ-019 In IDLE, valid_i && ready_o SHALL capture the operands, op and word into registers (accept edge).
REQ-020 With word_i=1, the captured operands SHALL be the low 32 bits, sign-extended for DIV/REM and zero-extended for DIVU/REMU.
REQ-021 div_sign_o SHALL be 1 for DIV and REM, and 0 otherwise; it is held constant from accept until leaving DONE.
REQ-022 Special cases SHALL be detected on the extended operands at accept, and the FSM goes IDLE->DONE with no divider start:
- divisor==0: quotient all-ones, remainder = dividend.
- signed overflow (dividend = most negative value at the effective width, divisor = -1): quotient = dividend, remainder = 0.
REQ-023 Otherwise the FSM SHALL go IDLE->START, and div_start_o is 1 for exactly the START cycle.
REQ-024 START SHALL always be followed by WAIT.
REQ-025 WAIT SHALL ignore div_finish_i in its first cycle only if div_start_o is still asserted; otherwise div_finish_i=1 moves WAIT->DONE.
REQ-026 The quotient or remainder SHALL be captured into a result register on that transition, selected by op_i[1].
REQ-027 The divider may finish in 0 extra cycles (dividend magnitude < divisor magnitude); WAIT SHALL accept div_finish_i in its first cycle.
REQ-028 div_divd_o and div_div_o SHALL stay stable from accept until leaving DONE, because the divider output is combinational on them.
REQ-029 For W ops, result_o SHALL be the sign-extension of result bit 31; for non-W ops, the full width.
REQ-030 In DONE, valid_o SHALL be 1 and result_o constant until ready_i=1, which returns the FSM to IDLE.
REQ-031 Latency: a special case SHALL give valid_o one cycle after accept; a normal op gives valid_o one cycle after div_finish_i is sampled in WAIT.
REQ-032 flush_i=1 in any state SHALL force IDLE next cycle and drop valid_o; div_start_o is never asserted in the cycle after a flush.
REQ-033 flush_i SHALL take priority over acceptance and over ready_i.
REQ-034 A new accept after a flush SHALL restart the divider normally, with no wait for the abandoned op.
REQ-035 valid_i while not in IDLE SHALL be ignored (ready_o=0).

Reset
REQ-036 rst_n_i low SHALL immediately give: state IDLE, ready_o=1, valid_o=0, div_start_o=0, div_sign_o=0, result_o=0, operand registers 0.
REQ-037 Reset mid-operation SHALL discard the op; after release, the first accept behaves as from power-up.

Verification
REQ-038 DIVU 100/7, non-W: start pulse 1 cycle; after finish, result_o=14, valid_o held until ready_i.
REQ-039 REM rs1=-7, rs2=2: result_o=-1 (0xFFFF_FFFF_FFFF_FFFF); DIV with the same operands gives -3.
REQ-040 DIV rs2=0, rs1=5: valid_o one cycle after accept, result_o all-ones, div_start_o never pulsed; REMU gives 5.
REQ-041 DIVW rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF: overflow path, result_o=0xFFFF_FFFF_8000_0000.
REQ-042 DIVU 3/9: finish already high in the first WAIT cycle; result_o=0 with no hang.
REQ-043 flush_i in WAIT, then a new DIVU 10/3 accepted the next cycle: result_o=3, and the stale result is never presented.
